ant_world: RTL and testbench
============================

# ant_world

Behavioural maze model that sits on the opposite side of the ant-controller interface. It takes the controller's motion commands (FW, TLeft, TRight) and returns antenna readings (LAntenna, RAntenna). It keeps the ant's position and heading on an 8x8 grid with a parameterised wall map, and it counts steps and wall bumps. It is used on the DE1 as the stand-in environment for the ant FSM and as a self-checking world in simulation.

## Interface
- WALLS, 64'h0, wall bitmap; bit index = y*8 + x, 1 = wall
- START_X, 3'd0, x coordinate after reset
- START_Y, 3'd0, y coordinate after reset
- START_DIR, 2'b01, heading after reset (00 N, 01 E, 10 S, 11 W)
- GOAL_X, 3'd7, goal x coordinate
- GOAL_Y, 3'd7, goal y coordinate

Ports:
- CLK  in  1  system clock, single clock domain
- reset  in  1  synchronous, active-high reset
- step  in  1  request to apply one command; sampled only in IDLE
- FW  in  1  move forward one cell
- TLeft  in  1  rotate heading counter-clockwise
- TRight  in  1  rotate heading clockwise
- LAntenna  out  1  registered; 1 = wall or grid edge in the cell directly ahead
- RAntenna  out  1  registered; 1 = wall or grid edge in the cell on the ant's right side
- busy  out  1  high in INIT, TURN, MOVE and SENSE
- done  out  1  one-cycle pulse when a step completes
- pos_x  out  3  current x
- pos_y  out  3  current y
- heading  out  2  current heading
- at_goal  out  1  combinational; (pos_x, pos_y) == (GOAL_X, GOAL_Y)
- step_count  out  16  completed steps; saturates at 16'hFFFF
- bump_count  out  8  blocked forward moves; saturates at 8'hFF
- cmd_err  out  1  sticky; set when TLeft and TRight are both high in an accepted step

## Operation
- Direction deltas: N = y-1, E = x+1, S = y+1, W = x-1.
- Right of a heading = heading+1 mod 4. Any coordinate outside 0..7 counts as a wall.
- States:
  - INIT: entered on reset.
  - IDLE: waits for step.
  - TURN: applies the latched rotation.
  - MOVE: applies the latched forward move.
  - SENSE: registers the antenna values.
- INIT -> IDLE after one cycle. In INIT, LAntenna and RAntenna are computed from the reset position and heading. No done pulse is issued.
- IDLE -> TURN when step = 1. FW, TLeft and TRight are latched on that edge; later changes on those inputs are ignored.
- TURN:
  - TLeft only: heading-1 mod 4.
  - TRight only: heading+1 mod 4.
  - Neither: heading unchanged.
  - Both: heading unchanged and cmd_err <= 1.
  - TURN -> MOVE.
- MOVE: if latched FW = 1 and the target cell in the new heading is free, the position advances one cell. If FW = 1 and the target is a wall or edge, the position holds and bump_count increments. MOVE -> SENSE.
- SENSE: LAntenna and RAntenna are registered from the updated position and heading. step_count increments, done is 1 for the next cycle, and the state returns to IDLE.
- A step with FW = TLeft = TRight = 0 still completes, increments step_count and pulses done.
- step while busy = 1 is ignored; it is not queued.
- The start cell is not checked for a wall. Placing the start on a wall is a configuration error and its behaviour is undefined.

## Timing
- Reset values:
  - pos = (START_X, START_Y), heading = START_DIR.
  - LAntenna = 0, RAntenna = 0.
  - busy = 1 (INIT), done = 0.
  - step_count = 0, bump_count = 0, cmd_err = 0.
- Antennas are valid, and busy = 0, on the first cycle after reset deasserts plus one edge (INIT exit).
- A step sampled at edge N:
  - heading updates at edge N+1.
  - pos updates at edge N+2.
  - antennas, step_count and done update at edge N+3.
  - done is high for exactly one cycle after edge N+3; busy is high between edges N and N+3.
- The done cycle is IDLE, so step = 1 in that cycle is accepted. The maximum rate is one step every 4 cycles.
- reset = 1 in any state aborts the step in progress with no partial update. All registers return to their reset values at that edge.
- The counters hold at saturation and do not wrap.

## Test plan
- WALLS = 0, start (0,0) facing E. Reset -> after INIT LAntenna = 0, RAntenna = 0, busy = 0, done = 0.
- Seven FW-only steps from (0,0) facing E -> pos (7,0), LAntenna = 1, step_count = 7, bump_count = 0. An eighth FW step -> pos (7,0) unchanged, bump_count = 1, step_count = 8.
- From (7,0) facing E, step with TRight + FW -> heading 10 (S), pos (7,1), RAntenna = 0, LAntenna = 0.
- WALLS bit 9 (cell (1,1)) set, start (1,0) facing E, step with TRight only -> heading S, LAntenna = 1, RAntenna = 0 (cell (0,0) free). Next step FW -> bump_count = 1, pos stays (1,0).
- Accepted step with TLeft = TRight = 1 -> heading unchanged, cmd_err = 1, and cmd_err stays 1 through later steps until reset.
- Protocol checks:
  - step held high continuously -> done pulses every 4 cycles.
  - step pulsed in TURN or MOVE -> ignored.
  - reset asserted in MOVE -> pos and counters return to reset values, no done pulse.
  - GOAL = (7,0) reached -> at_goal = 1.

Source files
------------

// File: rtl/ant_world.sv
// Behavioural 8x8 maze world for the ant controller: applies FW/TLeft/TRight
// commands one step at a time and returns registered antenna readings.
module ant_world #(
  parameter logic [63:0] WALLS     = 64'h0,
  parameter logic [2:0]  START_X   = 3'd0,
  parameter logic [2:0]  START_Y   = 3'd0,
  parameter logic [1:0]  START_DIR = 2'b01,
  parameter logic [2:0]  GOAL_X    = 3'd7,
  parameter logic [2:0]  GOAL_Y    = 3'd7
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        step,
  input  logic        FW,
  input  logic        TLeft,
  input  logic        TRight,
  output logic        LAntenna,
  output logic        RAntenna,
  output logic        busy,
  output logic        done,
  output logic [2:0]  pos_x,
  output logic [2:0]  pos_y,
  output logic [1:0]  heading,
  output logic        at_goal,
  output logic [15:0] step_count,
  output logic [7:0]  bump_count,
  output logic        cmd_err
);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_TURN  = 3'd2,
    S_MOVE  = 3'd3,
    S_SENSE = 3'd4
  } state_t;

  state_t      state_q;
  logic [2:0]  pos_x_q, pos_y_q;
  logic [1:0]  heading_q;
  logic        lant_q, rant_q;
  logic        busy_q, done_q;
  logic [15:0] step_count_q;
  logic [7:0]  bump_count_q;
  logic        cmd_err_q;
  logic        fw_q, tl_q, tr_q;

  logic [1:0]  heading_d;
  logic [2:0]  pos_x_d, pos_y_d;
  logic        fwd_blocked_d, right_blocked_d;

  // Cell ahead of (x,y) in direction d is blocked if it leaves the grid or is a wall.
  function automatic logic blocked(input logic [2:0] x, input logic [2:0] y,
                                   input logic [1:0] d);
    logic       hit_edge;
    logic [2:0] nx, ny;
    hit_edge = 1'b0;
    nx = x;
    ny = y;
    case (d)
      2'd0: begin hit_edge = (y == 3'd0); ny = y - 3'd1; end
      2'd1: begin hit_edge = (x == 3'd7); nx = x + 3'd1; end
      2'd2: begin hit_edge = (y == 3'd7); ny = y + 3'd1; end
      default: begin hit_edge = (x == 3'd0); nx = x - 3'd1; end
    endcase
    return hit_edge | WALLS[{ny, nx}];
  endfunction

  always_comb begin
    heading_d = heading_q;
    if (tl_q && !tr_q) begin
      heading_d = heading_q - 2'd1;
    end else if (tr_q && !tl_q) begin
      heading_d = heading_q + 2'd1;
    end

    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    case (heading_q)
      2'd0:    pos_y_d = pos_y_q - 3'd1;
      2'd1:    pos_x_d = pos_x_q + 3'd1;
      2'd2:    pos_y_d = pos_y_q + 3'd1;
      default: pos_x_d = pos_x_q - 3'd1;
    endcase

    fwd_blocked_d   = blocked(pos_x_q, pos_y_q, heading_q);
    right_blocked_d = blocked(pos_x_q, pos_y_q, heading_q + 2'd1);
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q      <= S_INIT;
      pos_x_q      <= START_X;
      pos_y_q      <= START_Y;
      heading_q    <= START_DIR;
      lant_q       <= 1'b0;
      rant_q       <= 1'b0;
      busy_q       <= 1'b1;
      done_q       <= 1'b0;
      step_count_q <= 16'd0;
      bump_count_q <= 8'd0;
      cmd_err_q    <= 1'b0;
      fw_q         <= 1'b0;
      tl_q         <= 1'b0;
      tr_q         <= 1'b0;
    end else begin
      case (state_q)
        S_INIT: begin
          lant_q  <= fwd_blocked_d;
          rant_q  <= right_blocked_d;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        S_IDLE: begin
          done_q <= 1'b0;
          if (step) begin
            // Command is frozen here; input changes during the step are ignored.
            fw_q    <= FW;
            tl_q    <= TLeft;
            tr_q    <= TRight;
            busy_q  <= 1'b1;
            state_q <= S_TURN;
          end
        end
        S_TURN: begin
          heading_q <= heading_d;
          if (tl_q && tr_q) begin
            cmd_err_q <= 1'b1;
          end
          state_q <= S_MOVE;
        end
        S_MOVE: begin
          if (fw_q) begin
            if (fwd_blocked_d) begin
              if (bump_count_q != 8'hFF) begin
                bump_count_q <= bump_count_q + 8'd1;
              end
            end else begin
              pos_x_q <= pos_x_d;
              pos_y_q <= pos_y_d;
            end
          end
          state_q <= S_SENSE;
        end
        S_SENSE: begin
          lant_q <= fwd_blocked_d;
          rant_q <= right_blocked_d;
          if (step_count_q != 16'hFFFF) begin
            step_count_q <= step_count_q + 16'd1;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b1;
          state_q <= S_INIT;
        end
      endcase
    end
  end

  assign LAntenna   = lant_q;
  assign RAntenna   = rant_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pos_x      = pos_x_q;
  assign pos_y      = pos_y_q;
  assign heading    = heading_q;
  assign at_goal    = (pos_x_q == GOAL_X) && (pos_y_q == GOAL_Y);
  assign step_count = step_count_q;
  assign bump_count = bump_count_q;
  assign cmd_err    = cmd_err_q;

endmodule

// File: tb/tb_ant_world.sv
// Scoreboard bench for ant_world: a reference world model predicts each step's
// outcome, which is queued at issue time and compared when done pulses.
module tb_ant_world;

  localparam logic [63:0] WALLS_A = 64'h0;
  localparam logic [63:0] WALLS_B = 64'h200;

  typedef struct packed {
    logic [2:0]  x;
    logic [2:0]  y;
    logic [1:0]  h;
    logic        la;
    logic        ra;
    logic [15:0] sc;
    logic [7:0]  bc;
    logic        err;
  } ms_t;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic rst_a, step_a, fw_a, tl_a, tr_a;
  logic la_a, ra_a, busy_a, done_a, goal_a, err_a;
  logic [2:0] px_a, py_a;
  logic [1:0] hd_a;
  logic [15:0] sc_a;
  logic [7:0] bc_a;

  logic rst_b, step_b, fw_b, tl_b, tr_b;
  logic la_b, ra_b, busy_b, done_b, goal_b, err_b;
  logic [2:0] px_b, py_b;
  logic [1:0] hd_b;
  logic [15:0] sc_b;
  logic [7:0] bc_b;

  ant_world #(.WALLS(WALLS_A), .START_X(3'd0), .START_Y(3'd0), .START_DIR(2'b01),
              .GOAL_X(3'd7), .GOAL_Y(3'd0)) dut_a (
    .CLK(CLK), .reset(rst_a), .step(step_a), .FW(fw_a), .TLeft(tl_a), .TRight(tr_a),
    .LAntenna(la_a), .RAntenna(ra_a), .busy(busy_a), .done(done_a),
    .pos_x(px_a), .pos_y(py_a), .heading(hd_a), .at_goal(goal_a),
    .step_count(sc_a), .bump_count(bc_a), .cmd_err(err_a));

  ant_world #(.WALLS(WALLS_B), .START_X(3'd1), .START_Y(3'd0), .START_DIR(2'b01),
              .GOAL_X(3'd7), .GOAL_Y(3'd7)) dut_b (
    .CLK(CLK), .reset(rst_b), .step(step_b), .FW(fw_b), .TLeft(tl_b), .TRight(tr_b),
    .LAntenna(la_b), .RAntenna(ra_b), .busy(busy_b), .done(done_b),
    .pos_x(px_b), .pos_y(py_b), .heading(hd_b), .at_goal(goal_b),
    .step_count(sc_b), .bump_count(bc_b), .cmd_err(err_b));

  int checks = 0;
  int passed = 0;
  ms_t ma, mb;
  ms_t qa[$];
  ms_t qb[$];

  function automatic logic tb_blk(input logic [63:0] w, input int x, input int y,
                                  input logic [1:0] d);
    int nx, ny;
    nx = x;
    ny = y;
    case (d)
      2'd0: ny = y - 1;
      2'd1: nx = x + 1;
      2'd2: ny = y + 1;
      default: nx = x - 1;
    endcase
    if (nx < 0 || nx > 7 || ny < 0 || ny > 7) return 1'b1;
    return w[ny*8 + nx];
  endfunction

  function automatic ms_t model_start(input logic [63:0] w, input logic [2:0] x,
                                      input logic [2:0] y, input logic [1:0] h);
    ms_t r;
    r = '0;
    r.x = x;
    r.y = y;
    r.h = h;
    r.la = tb_blk(w, int'(x), int'(y), h);
    r.ra = tb_blk(w, int'(x), int'(y), h + 2'd1);
    return r;
  endfunction

  function automatic ms_t model_step(input ms_t m, input logic [63:0] w,
                                     input logic fw, input logic tl, input logic tr);
    ms_t r;
    r = m;
    if (tl && tr) r.err = 1'b1;
    else if (tl) r.h = m.h - 2'd1;
    else if (tr) r.h = m.h + 2'd1;
    if (fw) begin
      if (tb_blk(w, int'(r.x), int'(r.y), r.h)) begin
        if (r.bc != 8'hFF) r.bc = r.bc + 8'd1;
      end else begin
        case (r.h)
          2'd0: r.y = r.y - 3'd1;
          2'd1: r.x = r.x + 3'd1;
          2'd2: r.y = r.y + 3'd1;
          default: r.x = r.x - 3'd1;
        endcase
      end
    end
    if (r.sc != 16'hFFFF) r.sc = r.sc + 16'd1;
    r.la = tb_blk(w, int'(r.x), int'(r.y), r.h);
    r.ra = tb_blk(w, int'(r.x), int'(r.y), r.h + 2'd1);
    return r;
  endfunction

  function automatic ms_t obs_a();
    ms_t r;
    r = '{x: px_a, y: py_a, h: hd_a, la: la_a, ra: ra_a, sc: sc_a, bc: bc_a, err: err_a};
    return r;
  endfunction

  function automatic ms_t obs_b();
    ms_t r;
    r = '{x: px_b, y: py_b, h: hd_b, la: la_b, ra: ra_b, sc: sc_b, bc: bc_b, err: err_b};
    return r;
  endfunction

  function automatic string fmt(input ms_t m);
    return $sformatf("(%0d,%0d) h%0d L%0d R%0d sc%0d bc%0d err%0d",
                     m.x, m.y, m.h, m.la, m.ra, m.sc, m.bc, m.err);
  endfunction

  // Waits for the DUT to go idle, drives one step and queues the prediction.
  task automatic issue_a(input logic fw, input logic tl, input logic tr);
    int n = 0;
    while (busy_a !== 1'b0 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    step_a = 1'b1; fw_a = fw; tl_a = tl; tr_a = tr;
    ma = model_step(ma, WALLS_A, fw, tl, tr);
    qa.push_back(ma);
    @(posedge CLK);
    #1;
    step_a = 1'b0; fw_a = ~fw; tl_a = ~tl; tr_a = ~tr;
  endtask

  task automatic issue_b(input logic fw, input logic tl, input logic tr);
    int n = 0;
    while (busy_b !== 1'b0 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    step_b = 1'b1; fw_b = fw; tl_b = tl; tr_b = tr;
    mb = model_step(mb, WALLS_B, fw, tl, tr);
    qb.push_back(mb);
    @(posedge CLK);
    #1;
    step_b = 1'b0; fw_b = ~fw; tl_b = ~tl; tr_b = ~tr;
  endtask

  task automatic wait_done_a(output bit got);
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge CLK);
      if (done_a === 1'b1) got = 1'b1;
    end
  endtask

  task automatic wait_done_b(output bit got);
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge CLK);
      if (done_b === 1'b1) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    ms_t exp;
    @(posedge CLK);
    #1;
    rst_a = 1'b1; rst_b = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    exp = '{x: 3'd0, y: 3'd0, h: 2'd1, la: 1'b0, ra: 1'b0, sc: 16'd0, bc: 8'd0, err: 1'b0};
    checks++;
    if (obs_a() !== exp || busy_a !== 1'b1 || done_a !== 1'b0)
      $display("FAIL reset_state obs=%s busy=%0d done=%0d exp=%s busy=1 done=0",
               fmt(obs_a()), busy_a, done_a, fmt(exp));
    else passed++;
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge CLK);
    ma = model_start(WALLS_A, 3'd0, 3'd0, 2'd1);
    mb = model_start(WALLS_B, 3'd1, 3'd0, 2'd1);
    checks++;
    if (obs_a() !== ma || busy_a !== 1'b0 || done_a !== 1'b0 || goal_a !== 1'b0)
      $display("FAIL init_exit_a obs=%s busy=%0d done=%0d goal=%0d exp=%s busy=0 done=0 goal=0",
               fmt(obs_a()), busy_a, done_a, goal_a, fmt(ma));
    else passed++;
    // World B starts with a wall on its right, so RAntenna must read 1.
    checks++;
    if (obs_b() !== mb || busy_b !== 1'b0 || ra_b !== 1'b1)
      $display("FAIL init_exit_b obs=%s busy=%0d exp=%s busy=0 R=1",
               fmt(obs_b()), busy_b, fmt(mb));
    else passed++;
  endtask

  task automatic test_forward();
    bit got;
    ms_t exp;
    for (int s = 1; s <= 8; s++) begin
      issue_a(1'b1, 1'b0, 1'b0);
      wait_done_a(got);
      exp = qa.pop_front();
      checks++;
      if (!got || obs_a() !== exp)
        $display("FAIL fw_step%0d done=%0d obs=%s exp=%s", s, got, fmt(obs_a()), fmt(exp));
      else passed++;
      checks++;
      if (goal_a !== (exp.x == 3'd7 && exp.y == 3'd0))
        $display("FAIL at_goal_step%0d obs=%0d exp=%0d", s, goal_a,
                 (exp.x == 3'd7 && exp.y == 3'd0));
      else passed++;
    end
  endtask

  task automatic test_turn_move();
    bit got;
    ms_t exp;
    issue_a(1'b1, 1'b0, 1'b1);
    wait_done_a(got);
    exp = qa.pop_front();
    checks++;
    if (!got || obs_a() !== exp)
      $display("FAIL turn_right_fw done=%0d obs=%s exp=%s", got, fmt(obs_a()), fmt(exp));
    else passed++;
  endtask

  task automatic test_cmd_err();
    bit got;
    ms_t exp;
    issue_a(1'b0, 1'b1, 1'b1);
    wait_done_a(got);
    exp = qa.pop_front();
    checks++;
    if (!got || obs_a() !== exp)
      $display("FAIL cmd_err_set done=%0d obs=%s exp=%s", got, fmt(obs_a()), fmt(exp));
    else passed++;
    issue_a(1'b0, 1'b1, 1'b0);
    wait_done_a(got);
    exp = qa.pop_front();
    checks++;
    if (!got || obs_a() !== exp)
      $display("FAIL cmd_err_sticky done=%0d obs=%s exp=%s", got, fmt(obs_a()), fmt(exp));
    else passed++;
  endtask

  task automatic test_back_to_back();
    ms_t exp;
    int cnt = 0;
    for (int n = 0; n < 20 && busy_a !== 1'b0; n++) @(negedge CLK);
    step_a = 1'b1; fw_a = 1'b0; tl_a = 1'b0; tr_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ma = model_step(ma, WALLS_A, 1'b0, 1'b0, 1'b0);
      qa.push_back(ma);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      if (done_a === 1'b1) begin
        exp = qa.pop_front();
        checks++;
        if (i != 3 + 4 * cnt || obs_a() !== exp)
          $display("FAIL b2b_done%0d cycle=%0d obs=%s exp_cycle=%0d exp=%s",
                   cnt, i, fmt(obs_a()), 3 + 4 * cnt, fmt(exp));
        else passed++;
        cnt++;
      end
      if (i == 15) step_a = 1'b0;
    end
    checks++;
    if (cnt != 4) $display("FAIL b2b_count obs=%0d exp=4", cnt);
    else passed++;
    qa.delete();
  endtask

  task automatic test_ignored_step();
    ms_t exp;
    int cnt = 0;
    for (int n = 0; n < 20 && busy_a !== 1'b0; n++) @(negedge CLK);
    step_a = 1'b1; fw_a = 1'b1; tl_a = 1'b0; tr_a = 1'b0;
    ma = model_step(ma, WALLS_A, 1'b1, 1'b0, 1'b0);
    qa.push_back(ma);
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (done_a === 1'b1) begin
        exp = qa.pop_front();
        checks++;
        if (i != 3 || obs_a() !== exp)
          $display("FAIL ignored_step_result cycle=%0d obs=%s exp_cycle=3 exp=%s",
                   i, fmt(obs_a()), fmt(exp));
        else passed++;
        cnt++;
      end
      if (i == 0) begin
        tl_a = 1'b1;
        fw_a = 1'b0;
      end
      if (i == 2) step_a = 1'b0;
    end
    checks++;
    if (cnt != 1) $display("FAIL ignored_step_count obs=%0d exp=1", cnt);
    else passed++;
    qa.delete();
    tl_a = 1'b0;
  endtask

  task automatic test_reset_in_move();
    ms_t exp;
    int cnt = 0;
    for (int n = 0; n < 20 && busy_a !== 1'b0; n++) @(negedge CLK);
    step_a = 1'b1; fw_a = 1'b1; tl_a = 1'b0; tr_a = 1'b1;
    @(posedge CLK);
    #1;
    step_a = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    rst_a = 1'b1;
    @(negedge CLK);
    rst_a = 1'b0;
    exp = '{x: 3'd0, y: 3'd0, h: 2'd1, la: 1'b0, ra: 1'b0, sc: 16'd0, bc: 8'd0, err: 1'b0};
    checks++;
    if (obs_a() !== exp || busy_a !== 1'b1 || done_a !== 1'b0)
      $display("FAIL reset_in_move obs=%s busy=%0d done=%0d exp=%s busy=1 done=0",
               fmt(obs_a()), busy_a, done_a, fmt(exp));
    else passed++;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (done_a === 1'b1) cnt++;
    end
    checks++;
    if (cnt != 0) $display("FAIL reset_in_move_done obs=%0d exp=0", cnt);
    else passed++;
    ma = model_start(WALLS_A, 3'd0, 3'd0, 2'd1);
    qa.delete();
  endtask

  task automatic test_walls();
    bit got;
    ms_t exp;
    issue_b(1'b0, 1'b0, 1'b1);
    wait_done_b(got);
    exp = qb.pop_front();
    checks++;
    if (!got || obs_b() !== exp || la_b !== 1'b1 || ra_b !== 1'b0)
      $display("FAIL wall_sense done=%0d obs=%s exp=%s", got, fmt(obs_b()), fmt(exp));
    else passed++;
    issue_b(1'b1, 1'b0, 1'b0);
    wait_done_b(got);
    exp = qb.pop_front();
    checks++;
    if (!got || obs_b() !== exp || bc_b !== 8'd1 || px_b !== 3'd1 || py_b !== 3'd0)
      $display("FAIL wall_bump done=%0d obs=%s exp=%s", got, fmt(obs_b()), fmt(exp));
    else passed++;
  endtask

  task automatic test_bump_sat();
    bit got;
    ms_t exp;
    issue_a(1'b0, 1'b1, 1'b0);
    wait_done_a(got);
    exp = qa.pop_front();
    checks++;
    if (!got || obs_a() !== exp)
      $display("FAIL face_north done=%0d obs=%s exp=%s", got, fmt(obs_a()), fmt(exp));
    else passed++;
    for (int s = 1; s <= 258; s++) begin
      issue_a(1'b1, 1'b0, 1'b0);
      wait_done_a(got);
      exp = qa.pop_front();
      checks++;
      if (!got || obs_a() !== exp)
        $display("FAIL bump_sat%0d done=%0d obs=%s exp=%s", s, got, fmt(obs_a()), fmt(exp));
      else passed++;
    end
    checks++;
    if (bc_a !== 8'hFF) $display("FAIL bump_hold obs=%0d exp=255", bc_a);
    else passed++;
  endtask

  initial begin
    rst_a = 1'b1; step_a = 1'b0; fw_a = 1'b0; tl_a = 1'b0; tr_a = 1'b0;
    rst_b = 1'b1; step_b = 1'b0; fw_b = 1'b0; tl_b = 1'b0; tr_b = 1'b0;
    test_reset();
    test_forward();
    test_turn_move();
    test_cmd_err();
    test_back_to_back();
    test_ignored_step();
    test_reset_in_move();
    test_walls();
    test_bump_sat();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
